nr_w1_byte_memory: RTL and testbench

Parametrised, synthesizable word memory with one byte-strobed write port and `NUM_RD` independent read ports. It serves as the instruction/data store of the simple processor and its successors. It adds the following:

- a sequential clear-on-reset engine;
- selectable 0- or 1-cycle read latency;
- a configurable read-during-write policy;
- out-of-range error reporting.

---
 rtl/nr_w1_byte_memory.sv | 144 ++++++++++++++
 tb/tb_nr_w1_byte_memory.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nr_w1_byte_memory.sv
// Word memory: one byte-strobed write port, NUM_RD read ports, clears itself to zero after reset.
// Latency: writes land at the sampling edge; reads are combinational (RD_LATENCY=0) or registered (RD_LATENCY=1).
// Backpressure: none; accesses are ignored until init_done_o, then every access completes.
module nr_w1_byte_memory #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int NUM_RD      = 2,
  parameter int RD_LATENCY  = 1,
  parameter int WRITE_FIRST = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  output logic                           init_done_o,
  input  logic                           we_i,
  input  logic [ADDR_WIDTH-1:0]          w_addr_i,
  input  logic [DATA_WIDTH-1:0]          w_data_i,
  input  logic [DATA_WIDTH/8-1:0]        w_strb_i,
  output logic                           w_err_o,
  input  logic [NUM_RD-1:0]              r_en_i,
  input  logic [NUM_RD*ADDR_WIDTH-1:0]   r_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0]   r_data_o,
  output logic [NUM_RD-1:0]              r_valid_o,
  output logic [NUM_RD-1:0]              r_err_o
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int BW = $clog2(NB);
  localparam int IW = ADDR_WIDTH - BW;
  localparam int MW = $clog2(DEPTH);

  localparam logic ST_INIT  = 1'b0;
  localparam logic ST_READY = 1'b1;

  logic                  state_q;
  logic [MW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  ready;
  logic [IW-1:0]         w_idx;
  logic                  w_in_range;
  logic                  w_fire;
  logic                  w_err_q;

  assign ready       = (state_q == ST_READY);
  assign init_done_o = ready;

  // Word index drops the byte-offset bits; anything at or beyond DEPTH is out of range.
  assign w_idx      = IW'(w_addr_i >> BW);
  assign w_in_range = ((w_idx >> MW) == '0);
  assign w_fire     = ready && we_i && w_in_range;

  // Init sequencer: walks the counter over every word once, then parks in READY.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else if (state_q == ST_INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == MW'(DEPTH - 1)) begin
        state_q <= ST_READY;
      end
    end
  end

  // Storage: init clears take the port while in INIT, external byte writes only when READY.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (!ready) begin
        mem[cnt_q] <= '0;
      end else if (w_fire) begin
        for (int b = 0; b < NB; b++) begin
          if (w_strb_i[b]) begin
            mem[w_idx[MW-1:0]][8*b +: 8] <= w_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  // Out-of-range write flag, one cycle after the offending write is sampled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_err_q <= 1'b0;
    end else begin
      w_err_q <= ready && we_i && !w_in_range;
    end
  end

  assign w_err_o = w_err_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [IW-1:0]         r_idx;
    logic                  r_in_range;
    logic [DATA_WIDTH-1:0] r_old;

    assign r_idx      = IW'(r_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH] >> BW);
    assign r_in_range = ((r_idx >> MW) == '0);
    assign r_old      = mem[r_idx[MW-1:0]];

    if (RD_LATENCY == 0) begin : g_comb
      // Combinational read sees pre-edge contents; outputs are forced low until init completes.
      assign r_data_o[p*DATA_WIDTH +: DATA_WIDTH] = (ready && r_en_i[p] && r_in_range) ? r_old : '0;
      assign r_valid_o[p] = ready && r_en_i[p];
      assign r_err_o[p]   = ready && r_en_i[p] && !r_in_range;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_fwd;
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;
      logic                  err_q;

      // Same-word write in this cycle: optionally forward strobed bytes so the read returns new data.
      always_comb begin
        r_fwd = r_old;
        if ((WRITE_FIRST != 0) && w_fire && (w_idx == r_idx)) begin
          for (int b = 0; b < NB; b++) begin
            if (w_strb_i[b]) begin
              r_fwd[8*b +: 8] = w_data_i[8*b +: 8];
            end
          end
        end
      end

      // Registered read: data holds when idle, zero for out-of-range, everything low during init.
      always_ff @(posedge clk_i) begin
        if (rst_i || !ready) begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= r_en_i[p];
          err_q   <= r_en_i[p] && !r_in_range;
          if (r_en_i[p]) begin
            data_q <= r_in_range ? r_fwd : '0;
          end
        end
      end

      assign r_data_o[p*DATA_WIDTH +: DATA_WIDTH] = data_q;
      assign r_valid_o[p] = valid_q;
      assign r_err_o[p]   = err_q;
    end
  end

endmodule

// File: tb/tb_nr_w1_byte_memory.sv
// Bench for nr_w1_byte_memory: three instances (latency 1 write-first, latency 1 read-first, latency 0)
// share one stimulus stream and are compared against a word-array reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled away from the edge.
module tb_nr_w1_byte_memory;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int NR    = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             we;
  logic [AW-1:0]    w_addr;
  logic [DW-1:0]    w_data;
  logic [3:0]       w_strb;
  logic [NR-1:0]    r_en;
  logic [NR*AW-1:0] r_addr;

  logic             done_wf, done_rf, done_c;
  logic             werr_wf, werr_rf, werr_c;
  logic [NR*DW-1:0] rdata_wf, rdata_rf, rdata_c;
  logic [NR-1:0]    rvalid_wf, rvalid_rf, rvalid_c;
  logic [NR-1:0]    rerr_wf, rerr_rf, rerr_c;

  nr_w1_byte_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR),
                      .RD_LATENCY(1), .WRITE_FIRST(1)) u_wf (
    .clk_i(clk), .rst_i(rst), .init_done_o(done_wf), .we_i(we), .w_addr_i(w_addr),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_err_o(werr_wf), .r_en_i(r_en),
    .r_addr_i(r_addr), .r_data_o(rdata_wf), .r_valid_o(rvalid_wf), .r_err_o(rerr_wf));

  nr_w1_byte_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR),
                      .RD_LATENCY(1), .WRITE_FIRST(0)) u_rf (
    .clk_i(clk), .rst_i(rst), .init_done_o(done_rf), .we_i(we), .w_addr_i(w_addr),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_err_o(werr_rf), .r_en_i(r_en),
    .r_addr_i(r_addr), .r_data_o(rdata_rf), .r_valid_o(rvalid_rf), .r_err_o(rerr_rf));

  nr_w1_byte_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_RD(NR),
                      .RD_LATENCY(0), .WRITE_FIRST(1)) u_c (
    .clk_i(clk), .rst_i(rst), .init_done_o(done_c), .we_i(we), .w_addr_i(w_addr),
    .w_data_i(w_data), .w_strb_i(w_strb), .w_err_o(werr_c), .r_en_i(r_en),
    .r_addr_i(r_addr), .r_data_o(rdata_c), .r_valid_o(rvalid_c), .r_err_o(rerr_c));

  // Reference model: plain word array plus the last data each registered port returned.
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] last_wf [NR];
  logic [DW-1:0] last_rf [NR];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int p = 0; p < NR; p++) begin
      last_wf[p] = '0;
      last_rf[p] = '0;
    end
  endtask

  // All externally visible outputs must be quiet (reset and init behaviour).
  task automatic chk_quiet(input string tag);
    chk({tag, "_done"}, {31'd0, done_wf | done_rf | done_c}, 32'd0);
    chk({tag, "_werr"}, {29'd0, werr_wf, werr_rf, werr_c}, 32'd0);
    chk({tag, "_valid"}, {23'd0, rvalid_wf, rvalid_rf, rvalid_c}, 32'd0);
    chk({tag, "_rerr"}, {23'd0, rerr_wf, rerr_rf, rerr_c}, 32'd0);
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("%s_rdata_wf%0d", tag, p), rdata_wf[p*DW +: DW], '0);
      chk($sformatf("%s_rdata_rf%0d", tag, p), rdata_rf[p*DW +: DW], '0);
    end
  endtask

  // Hold reset for n edges while hammering the inputs, then release it.
  task automatic do_reset(input int n);
    rst = 1'b1; we = 1'b1; w_addr = 12'h014; w_data = 32'hFFFF_FFFF; w_strb = 4'hF;
    r_en = '1; r_addr = {12'h014, 12'h014, 12'h014};
    repeat (n) @(posedge clk);
    #1;
    chk_quiet("in_reset");
    rst = 1'b0;
    model_clear();
  endtask

  // Count edges until init completes, with a bound; writes stay asserted throughout.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (i == 1) chk_quiet({tag, "_after_reset"});
      if (done_wf) break;
    end
    chk({tag, "_init_edges"}, n, 16);
    chk({tag, "_done_all"}, {29'd0, done_wf, done_rf, done_c}, 32'h7);
  endtask

  // One access cycle on all instances, checked against the model.
  task automatic access(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [3:0] ws, input logic [NR-1:0] en,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    logic [AW-1:0] ra [NR];
    logic [DW-1:0] exp_wf [NR];
    logic [DW-1:0] exp_rf [NR];
    int widx, idx;
    logic woor, oor;
    logic [DW-1:0] old_v, new_v;
    ra[0] = a0; ra[1] = a1; ra[2] = a2;
    we = w; w_addr = wa; w_data = wd; w_strb = ws; r_en = en; r_addr = {a2, a1, a0};
    widx = int'(wa) / 4;
    woor = (widx >= DEPTH);
    #1;
    for (int p = 0; p < NR; p++) begin
      idx = int'(ra[p]) / 4;
      oor = (idx >= DEPTH);
      old_v = oor ? '0 : mem_m[idx];
      new_v = old_v;
      if (w && !woor && widx == idx)
        for (int b = 0; b < 4; b++) if (ws[b]) new_v[8*b +: 8] = wd[8*b +: 8];
      chk($sformatf("c_valid%0d", p), {31'd0, rvalid_c[p]}, {31'd0, en[p]});
      if (en[p]) begin
        chk($sformatf("c_err%0d", p), {31'd0, rerr_c[p]}, {31'd0, oor});
        chk($sformatf("c_data%0d", p), rdata_c[p*DW +: DW], old_v);
      end
      exp_wf[p] = en[p] ? new_v : last_wf[p];
      exp_rf[p] = en[p] ? old_v : last_rf[p];
      ra[p] = oor ? 12'h1 : 12'h0;   // reuse slot to remember out-of-range for after the edge
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("wf_valid%0d", p), {31'd0, rvalid_wf[p]}, {31'd0, en[p]});
      chk($sformatf("rf_valid%0d", p), {31'd0, rvalid_rf[p]}, {31'd0, en[p]});
      chk($sformatf("wf_data%0d", p), rdata_wf[p*DW +: DW], exp_wf[p]);
      chk($sformatf("rf_data%0d", p), rdata_rf[p*DW +: DW], exp_rf[p]);
      if (en[p]) begin
        chk($sformatf("wf_err%0d", p), {31'd0, rerr_wf[p]}, {31'd0, ra[p][0]});
        chk($sformatf("rf_err%0d", p), {31'd0, rerr_rf[p]}, {31'd0, ra[p][0]});
      end
      last_wf[p] = exp_wf[p];
      last_rf[p] = exp_rf[p];
    end
    chk("w_err", {29'd0, werr_wf, werr_rf, werr_c}, (w && woor) ? 32'h7 : 32'h0);
    if (w && !woor)
      for (int b = 0; b < 4; b++) if (ws[b]) mem_m[widx][8*b +: 8] = wd[8*b +: 8];
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; w_addr = '0; w_data = '0; w_strb = '0; r_en = '0; r_addr = '0;
    model_clear();
    @(negedge clk);

    // Reset and init; writes driven during init must be dropped.
    do_reset(2);
    wait_init("init1");
    access(1'b0, 12'h0, 32'h0, 4'h0, 3'b001, 12'h014, 12'h0, 12'h0);
    chk("word5_zero", rdata_wf[0 +: DW], 32'h0000_0000);

    // Strobed writes, read back through aliased byte offsets.
    access(1'b1, 12'h010, 32'hDEAD_BEEF, 4'b1111, 3'b000, 12'h0, 12'h0, 12'h0);
    access(1'b1, 12'h010, 32'h00AA_0000, 4'b0100, 3'b000, 12'h0, 12'h0, 12'h0);
    access(1'b0, 12'h0, 32'h0, 4'h0, 3'b011, 12'h010, 12'h013, 12'h0);
    chk("strobe_p0", rdata_wf[0 +: DW], 32'hDEAA_BEEF);
    chk("strobe_p1", rdata_wf[DW +: DW], 32'hDEAA_BEEF);

    // Read during write on port 1.
    access(1'b1, 12'h020, 32'h1111_1111, 4'b1111, 3'b000, 12'h0, 12'h0, 12'h0);
    access(1'b1, 12'h020, 32'h2222_2222, 4'b0011, 3'b010, 12'h0, 12'h020, 12'h0);
    chk("rdw_write_first", rdata_wf[DW +: DW], 32'h1111_2222);
    chk("rdw_read_first", rdata_rf[DW +: DW], 32'h1111_1111);

    // Out-of-range write then read.
    access(1'b1, 12'h040, 32'h5555_5555, 4'b1111, 3'b000, 12'h0, 12'h0, 12'h0);
    chk("oor_werr", {31'd0, werr_wf}, 32'd1);
    access(1'b0, 12'h0, 32'h0, 4'h0, 3'b111, 12'h040, 12'h040, 12'h040);
    chk("oor_werr_gone", {31'd0, werr_wf}, 32'd0);
    chk("oor_rvalid", {29'd0, rvalid_wf}, 32'h7);
    chk("oor_rerr", {29'd0, rerr_wf}, 32'h7);
    chk("oor_rdata", rdata_wf[0 +: DW], 32'h0);

    // Multiport same word and neighbour.
    access(1'b1, 12'h014, 32'h0BAD_F00D, 4'b1111, 3'b000, 12'h0, 12'h0, 12'h0);
    access(1'b0, 12'h0, 32'h0, 4'h0, 3'b111, 12'h010, 12'h010, 12'h014);
    chk("mp_p2", rdata_wf[2*DW +: DW], 32'h0BAD_F00D);

    // Randomized traffic including out-of-range indices.
    for (int n = 0; n < 300; n++) begin
      access(1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
             $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
             AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
             AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)),
             AW'($urandom_range(0, 19) * 4 + $urandom_range(0, 3)));
    end

    // Reset mid-init: restart at init edge 7, then memory must be all zero.
    access(1'b1, 12'h014, 32'hCAFE_F00D, 4'b1111, 3'b000, 12'h0, 12'h0, 12'h0);
    do_reset(2);
    repeat (6) @(posedge clk);
    #1;
    chk("mid_init_done", {31'd0, done_wf}, 32'd0);
    do_reset(1);
    wait_init("init2");
    for (int i = 0; i < DEPTH; i += 3)
      access(1'b0, 12'h0, 32'h0, 4'h0, 3'b111, AW'(i * 4), AW'((i + 1) * 4), AW'((i + 2) * 4));
    chk("init2_word5", rdata_wf[2*DW +: DW], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
